// File: rtl/reg_ld_arbiter.sv
// Arbitrates four requesters onto a shared 8-entry register write port (ld strobe + Din bus).
// Define REG_LD_ARBITER_RR_EN for round-robin arbitration; default is fixed priority (req[0] first).
module reg_ld_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [2:0]  addr0,
   input  logic [2:0]  addr1,
   input  logic [2:0]  addr2,
   input  logic [2:0]  addr3,
   input  logic [31:0] data0,
   input  logic [31:0] data1,
   input  logic [31:0] data2,
   input  logic [31:0] data3,
   output logic [7:0]  ld,
   output logic [31:0] Din,
   output logic [3:0]  ack,
   output logic        busy
);

   typedef enum logic [0:0] {StIdle, StWrite} state_e;

   state_e      state_q, state_d;
   logic [7:0]  ld_q, ld_d;
   logic [31:0] din_q, din_d;
   logic [3:0]  ack_q, ack_d;
   logic        busy_q, busy_d;

   logic [2:0]  addr_arr [4];
   logic [31:0] data_arr [4];
   logic        win_valid;
   logic [1:0]  win_idx;

   assign addr_arr[0] = addr0;
   assign addr_arr[1] = addr1;
   assign addr_arr[2] = addr2;
   assign addr_arr[3] = addr3;
   assign data_arr[0] = data0;
   assign data_arr[1] = data1;
   assign data_arr[2] = data2;
   assign data_arr[3] = data3;

`ifdef REG_LD_ARBITER_RR_EN
   logic [1:0] ptr_q, ptr_d;

   // Search starts at the pointer and wraps; first set bit wins.
   always_comb begin
      logic [1:0] idx;
      win_valid = 1'b0;
      win_idx   = 2'd0;
      idx       = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!win_valid && req[idx]) begin
            win_valid = 1'b1;
            win_idx   = idx;
         end
      end
   end
`else
   always_comb begin
      win_valid = |req;
      win_idx   = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (req[k]) begin
            win_idx = 2'(k);
         end
      end
   end
`endif

   // The output registers themselves hold the captured grant for the WRITE cycle.
   always_comb begin
      state_d = state_q;
      ld_d    = 8'h00;
      din_d   = din_q;
      ack_d   = 4'h0;
      busy_d  = 1'b0;
`ifdef REG_LD_ARBITER_RR_EN
      ptr_d   = ptr_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (win_valid) begin
               state_d = StWrite;
               ld_d    = 8'h01 << addr_arr[win_idx];
               din_d   = data_arr[win_idx];
               ack_d   = 4'h1 << win_idx;
               busy_d  = 1'b1;
`ifdef REG_LD_ARBITER_RR_EN
               ptr_d   = win_idx + 2'd1;
`endif
            end
         end
         StWrite: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         ld_q    <= 8'h00;
         din_q   <= 32'h0;
         ack_q   <= 4'h0;
         busy_q  <= 1'b0;
`ifdef REG_LD_ARBITER_RR_EN
         ptr_q   <= 2'd0;
`endif
      end else begin
         state_q <= state_d;
         ld_q    <= ld_d;
         din_q   <= din_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
`ifdef REG_LD_ARBITER_RR_EN
         ptr_q   <= ptr_d;
`endif
      end
   end

   assign ld   = ld_q;
   assign Din  = din_q;
   assign ack  = ack_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_reg_ld_arbiter.sv
// Directed self-checking bench for reg_ld_arbiter; expectations follow REG_LD_ARBITER_RR_EN.
module tb_reg_ld_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [2:0]  addr0, addr1, addr2, addr3;
   logic [31:0] data0, data1, data2, data3;
   logic [7:0]  ld;
   logic [31:0] Din;
   logic [3:0]  ack;
   logic        busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   reg_ld_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .addr0 (addr0),
      .addr1 (addr1),
      .addr2 (addr2),
      .addr3 (addr3),
      .data0 (data0),
      .data1 (data1),
      .data2 (data2),
      .data3 (data3),
      .ld    (ld),
      .Din   (Din),
      .ack   (ack),
      .busy  (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Advance past the next active edge, then settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] exp_ack;
      logic [7:0] exp_ld;
      logic [31:0] exp_din;
      logic [2:0] a_tab [4];
      logic [31:0] d_tab [4];
      logic       prev_busy;
      logic [3:0] req_prev;
      int         gi;

      reset = 1'b0;
      req   = 4'h0;
      addr0 = 3'd0; addr1 = 3'd0; addr2 = 3'd0; addr3 = 3'd0;
      data0 = 32'h0; data1 = 32'h0; data2 = 32'h0; data3 = 32'h0;
      #12;
      check("rst_ld",   {24'h0, ld},  32'h0);
      check("rst_din",  Din,          32'h0);
      check("rst_ack",  {28'h0, ack}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      step();
      reset = 1'b1;

      step();
      check("idle_busy", {31'h0, busy}, 32'h0);
      check("idle_ack",  {28'h0, ack},  32'h0);

      // Single request from requester 0.
      req = 4'b0001; addr0 = 3'd5; data0 = 32'hDEADBEEF;
      step();
      check("single_ld",   {24'h0, ld},  32'h20);
      check("single_din",  Din,          32'hDEADBEEF);
      check("single_ack",  {28'h0, ack}, 32'h1);
      check("single_busy", {31'h0, busy}, 32'h1);
      req = 4'b0000;
      step();
      check("single_end_ld",   {24'h0, ld},  32'h0);
      check("single_end_ack",  {28'h0, ack}, 32'h0);
      check("single_end_busy", {31'h0, busy}, 32'h0);
      check("single_din_hold", Din,          32'hDEADBEEF);

      // Reset clears the round-robin pointer before the all-requesters run.
      reset = 1'b0;
      #2;
      reset = 1'b1;

      a_tab[0] = 3'd0; a_tab[1] = 3'd7; a_tab[2] = 3'd2; a_tab[3] = 3'd6;
      d_tab[0] = 32'hA0; d_tab[1] = 32'hA1; d_tab[2] = 32'hA2; d_tab[3] = 32'hA3;
      addr0 = a_tab[0]; addr1 = a_tab[1]; addr2 = a_tab[2]; addr3 = a_tab[3];
      data0 = d_tab[0]; data1 = d_tab[1]; data2 = d_tab[2]; data3 = d_tab[3];
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
`ifdef REG_LD_ARBITER_RR_EN
         gi = g % 4;
`else
         gi = 0;
`endif
         exp_ack = 4'h1 << gi;
         exp_ld  = 8'h01 << a_tab[gi];
         exp_din = d_tab[gi];
         step();
         check($sformatf("all_ack%0d", g), {28'h0, ack}, {28'h0, exp_ack});
         check($sformatf("all_ld%0d", g),  {24'h0, ld},  {24'h0, exp_ld});
         check($sformatf("all_din%0d", g), Din,          exp_din);
         step();
         check($sformatf("all_gap%0d", g), {31'h0, busy}, 32'h0);
      end
      req = 4'b0000;

      // Reset during WRITE aborts it; the held request is granted afterwards.
      req = 4'b1000; addr3 = 3'd7; data3 = 32'hC0FFEE01;
      step();
      check("abort_pre_ack", {28'h0, ack}, 32'h8);
      check("abort_pre_ld",  {24'h0, ld},  32'h80);
      #1 reset = 1'b0;
      #1;
      check("abort_ld",   {24'h0, ld},  32'h0);
      check("abort_ack",  {28'h0, ack}, 32'h0);
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_din",  Din,          32'h0);
      #1 reset = 1'b1;
      step();
      check("regrant_ack", {28'h0, ack}, 32'h8);
      check("regrant_ld",  {24'h0, ld},  32'h80);
      check("regrant_din", Din,          32'hC0FFEE01);
      req = 4'b0000;
      step();

      // Two requesters, same register: 1 then 2 (pointer is 0 here under round-robin).
      addr1 = 3'd3; data1 = 32'h11; addr2 = 3'd3; data2 = 32'h22;
      req = 4'b0110;
      step();
      check("same_ack1", {28'h0, ack}, 32'h2);
      check("same_ld1",  {24'h0, ld},  32'h08);
      check("same_din1", Din,          32'h11);
      req = 4'b0100;
      step();
      check("same_gap", {31'h0, busy}, 32'h0);
      step();
      check("same_ack2", {28'h0, ack}, 32'h4);
      check("same_ld2",  {24'h0, ld},  32'h08);
      check("same_din2", Din,          32'h22);
      req = 4'b0000;
      step();

      // Short random run with a protocol-following requester model.
      prev_busy = 1'b0;
      req_prev  = 4'h0;
      for (int c = 0; c < 300; c++) begin
         step();
         check("rnd_ld_onehot",  {31'h0, $onehot0(ld)},  32'h1);
         check("rnd_ack_onehot", {31'h0, $onehot0(ack)}, 32'h1);
         check("rnd_busy_twice", {31'h0, busy & prev_busy}, 32'h0);
         check("rnd_ack_req",    {28'h0, ack & ~req_prev}, 32'h0);
         prev_busy = busy;
         for (int i = 0; i < 4; i++) begin
            if (ack[i]) begin
               req[i] = 1'b0;
            end else if (!req[i] && ($urandom_range(3) == 0)) begin
               req[i] = 1'b1;
               case (i)
                  0: begin addr0 = 3'($urandom_range(7)); data0 = $urandom; end
                  1: begin addr1 = 3'($urandom_range(7)); data1 = $urandom; end
                  2: begin addr2 = 3'($urandom_range(7)); data2 = $urandom; end
                  default: begin addr3 = 3'($urandom_range(7)); data3 = $urandom; end
               endcase
            end
         end
         req_prev = req;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_ld_arbiter.md
REG_LD_ARBITER -- requirements
Module: reg_ld_arbiter

Interface
REQ-001: clk  input  1  single clock; all state updates on posedge clk.
REQ-002: reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately, independent of clk.
REQ-003: req  input  4  per-requester write request; bit i is held high by requester i until it sees ack[i].
REQ-004: addr0..addr3  input  3 each  target register index (0..7) of requester i; stable while req[i]=1.
REQ-005: data0..data3  input  32 each  write data of requester i; stable while req[i]=1.
REQ-006: ld  output  8  one-hot load strobe; bit k drives the ld input of 32-bit load-enabled register k.
REQ-007: Din  output  32  shared data bus to all 8 registers.
REQ-008: ack  output  4  one-hot, one-cycle write-complete pulse to the granted requester.
REQ-009: busy  output  1  high while a write is in flight (state WRITE).

Function
REQ-010: Two-state FSM: IDLE, WRITE; ld, Din, ack and busy are registered outputs.
REQ-011: IDLE with req=0: remain IDLE; ld=0, ack=0, busy=0, Din holds its last value.
REQ-012: IDLE with any req bit set at edge N: select one winner, capture its index, addr and data, go to WRITE.
REQ-013: WRITE (cycle after edge N): ld = one-hot of captured addr, Din = captured data, ack[winner]=1, busy=1, for exactly one cycle.
REQ-014: WRITE always returns to IDLE at the next edge; req is not sampled in WRITE.
REQ-015: Latency: req high in cycle N gives ld/ack in cycle N+1; max throughput is one write per 2 cycles.
REQ-016: Requester protocol: requester i drops req[i] (or presents a new addr/data) at the edge where it samples ack[i]=1.
REQ-017: At most one ld bit and at most one ack bit are high in any cycle.
REQ-018: Simultaneous requests to the same addr serialize by arbitration; the later grant's data is the final register value.
REQ-019: Requests not granted stay pending with no timeout; no request is dropped.
REQ-020: Arbitration order is defined in REQ-025/REQ-026; the winner index is the only state carried between grants.

Reset
REQ-021: While reset=0: state=IDLE, ld=0, Din=32'h0, ack=0, busy=0, priority pointer=0.
REQ-022: Reset asserted while in WRITE aborts the write asynchronously; ld and ack are forced low and no ack is issued for that request.
REQ-023: The first sampling of req occurs at the first posedge clk after reset deasserts.
REQ-024: An aborted requester keeps req high and is re-arbitrated normally after reset.

Configuration
REQ-025: Macro REG_LD_ARBITER_RR_EN defined: round-robin arbitration; 2-bit pointer p; the search runs p, p+1, ... mod 4; after granting i, p becomes (i+1) mod 4.
REQ-026: Macro REG_LD_ARBITER_RR_EN undefined: fixed priority, req[0] highest and req[3] lowest; no pointer state exists.

Verification
REQ-027: Single: req=4'b0001, addr0=5, data0=32'hDEADBEEF -> next cycle ld=8'b0010_0000, Din=32'hDEADBEEF, ack=4'b0001, busy=1; then idle.
REQ-028: All four held high continuously with RR_EN -> ack order 0,1,2,3,0 on every second cycle; without RR_EN -> ack only to requester 0 while req[0]=1.
REQ-029: req[1] and req[2] both targeting addr 3, data 32'h11 and 32'h22, RR_EN, p=0 -> writes 32'h11 then 32'h22, in cycles N+1 and N+3.
REQ-030: reset pulled low during WRITE -> ld=0, ack=0 immediately; after release, same held req -> granted and acked within 2 cycles.
REQ-031: Random req/addr/data for 10k cycles -> ld and ack always one-hot or zero, never two consecutive busy cycles, every request eventually acked (RR_EN).
